// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, op and state encodings, instruction field layout
package mem_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 8;

  // Instruction word: opcode in the top three bits, operand address below it
  localparam int INSTR_W     = 16;
  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 13;
  localparam int OPERAND_MSB = 12;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [1:0] {
    OP_FETCH   = 2'b00,
    OP_LOAD    = 2'b01,
    OP_STORE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_LO = 3'd1,
    S_FETCH_HI = 3'd2,
    S_LOAD     = 3'd3,
    S_STORE    = 3'd4,
    S_RESP     = 3'd5
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-wide memory initiator sequencing fetch, load and store requests
import mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_data,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wen,
  input  logic [DATA_W-1:0]   mem_rdata
);

  mau_state_e          state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   lo_q;

  // mem_addr is loaded at the accept edge so the combinational read data is
  // already valid during the first access state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wen    <= 1'b0;
      addr_q     <= '0;
      lo_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mem_wen    <= 1'b0;
      case (state)
        S_FETCH_LO: begin
          lo_q     <= mem_rdata;
          mem_addr <= addr_q + 1'b1;
          state    <= S_FETCH_HI;
        end
        S_FETCH_HI: begin
          resp_valid <= 1'b1;
          resp_data  <= {mem_rdata, lo_q};
          req_ready  <= 1'b1;
          state      <= S_RESP;
        end
        S_LOAD: begin
          resp_valid <= 1'b1;
          resp_data  <= {{DATA_W{mem_rdata[DATA_W-1]}}, mem_rdata};
          req_ready  <= 1'b1;
          state      <= S_RESP;
        end
        S_STORE: begin
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= S_RESP;
        end
        default: begin
          if (req_valid && req_ready) begin
            addr_q <= req_addr;
            case (mem_op_e'(req_op))
              OP_FETCH: begin
                mem_addr  <= req_addr;
                req_ready <= 1'b0;
                state     <= S_FETCH_LO;
              end
              OP_LOAD: begin
                mem_addr  <= req_addr;
                req_ready <= 1'b0;
                state     <= S_LOAD;
              end
              OP_STORE: begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                mem_wen   <= 1'b1;
                req_ready <= 1'b0;
                state     <= S_STORE;
              end
              default: begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                req_ready  <= 1'b1;
                state      <= S_RESP;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit against a memory-level model
`timescale 1ns/1ps

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [12:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic [7:0]  mem_rdata;

  logic [7:0] mem     [0:8191];
  logic [7:0] ref_mem [0:8191];
  int n_checks = 0;
  int n_pass   = 0;
  int wen_count = 0;
  time acc_t;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wen_count = wen_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Issues one request starting at a falling edge and returns at the falling
  // edge of its response cycle, so a following call lands back-to-back.
  task automatic do_req(input logic [1:0] op, input logic [12:0] a, input logic [7:0] wd);
    int k, bound, lat, wen0;
    logic [15:0] exp;
    logic quiet_ok;
    logic [12:0] a_next;
    a_next = 13'((int'(a) + 1) % 8192);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    bound = 0;
    while (!req_ready && bound < 10) begin
      @(negedge clk);
      bound++;
    end
    check("ready_wait", bound < 10, 1);
    acc_t = $time;
    wen0 = wen_count;
    case (op)
      2'd0: begin lat = 3; exp = {ref_mem[a_next], ref_mem[a]}; end
      2'd1: begin lat = 2; exp = (ref_mem[a] >= 8'd128) ? 16'hFF00 + ref_mem[a] : {8'h00, ref_mem[a]}; end
      2'd2: begin lat = 2; exp = 16'h0; ref_mem[a] = wd; end
      default: begin lat = 1; exp = 16'h0; end
    endcase
    @(negedge clk);
    req_valid = 1'b0;
    req_op = $urandom; req_addr = $urandom; req_wdata = $urandom;
    k = 1;
    quiet_ok = 1'b1;
    while (!resp_valid && k < 8) begin
      if (resp_data != 0 || resp_err != 0) quiet_ok = 1'b0;
      check("busy_not_ready", req_ready, 0);
      if (k == 1) check("mem_addr_first", mem_addr, a);
      if (op == 2'd0 && k == 2) check("mem_addr_hi", mem_addr, a_next);
      if (op == 2'd2) begin
        check("store_wen", mem_wen, 1);
        check("store_wdata", mem_wdata, wd);
      end else begin
        check("no_wen", mem_wen, 0);
      end
      @(negedge clk);
      k++;
    end
    check("latency", k, lat);
    check("resp_data", resp_data, exp);
    check("resp_err", resp_err, op == 2'd3);
    check("quiet_until_resp", quiet_ok, 1);
    check("resp_ready", req_ready, 1);
    check("resp_no_wen", mem_wen, 0);
    check("write_count", wen_count - wen0, op == 2'd2);
  endtask

  initial begin
    time t1;
    logic [12:0] pick [0:5];
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    preload(0, 8'hE8); preload(1, 8'h03); preload(1000, 8'd50);
    preload(7, 8'h9C); preload(8191, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wen", mem_wen, 0);

    do_req(2'd0, 13'd0, 8'h00);
    check("fetch0_value", resp_data, 16'h03E8);
    @(negedge clk);
    do_req(2'd1, 13'd1000, 8'h00);
    check("load1000_value", resp_data, 16'h0032);
    do_req(2'd1, 13'd7, 8'h00);
    check("load7_value", resp_data, 16'hFF9C);
    do_req(2'd2, 13'd999, 8'h55);
    do_req(2'd1, 13'd999, 8'h00);
    check("store_load_value", resp_data, 16'h0055);
    @(negedge clk);
    do_req(2'd0, 13'd8191, 8'h00);
    check("fetch_wrap_value", resp_data, 16'hE811);
    do_req(2'd3, 13'd5, 8'hAA);
    do_req(2'd0, 13'd0, 8'h00);
    t1 = acc_t;
    do_req(2'd0, 13'd0, 8'h00);
    check("fetch_throughput", 32'((acc_t - t1) / 10), 3);

    // Reset aborts a fetch in its high-byte cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 13'd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_resp_valid", resp_valid, 0);
    check("abort_ready", req_ready, 1);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    check("abort_resp_data", resp_data, 0);
    check("abort_resp_err", resp_err, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
    end
    do_req(2'd1, 13'd1000, 8'h00);
    check("post_reset_load", resp_data, 16'h0032);

    pick[0] = 13'd0; pick[1] = 13'd1; pick[2] = 13'd999;
    pick[3] = 13'd1000; pick[4] = 13'd8191; pick[5] = 13'd8190;
    for (int n = 0; n < 60; n++) begin
      logic [12:0] a;
      a = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : 13'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(2'($urandom_range(0, 3)), a, 8'($urandom));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
